spu32_cpu_aluarb: RTL
=====================

SPU32_CPU_ALUARB -- requirements
Module: spu32_cpu_aluarb

Interface
REQ-001 SHALL have no parameters; all widths are fixed (operands 32 bit, aluop 4 bit).
REQ-002 SHALL have I_clk, input, 1, sole clock; all state updates on its rising edge.
REQ-003 SHALL have I_reset_n, input, 1: one clock; reset is asynchronous and active-low.
REQ-004 SHALL have, per requester N in {0,1}: I_pN_req (in, 1, request level); I_pN_op (in, 4, ALUOP code); I_pN_s1 and I_pN_s2 (in, 32, operands); O_pN_gnt (out, 1, accept pulse); O_pN_done (out, 1, completion pulse); O_pN_data (out, 32, result); O_pN_lt, O_pN_ltu, O_pN_eq (out, 1 each, comparison flags).
REQ-005 SHALL have the ALU-side ports: O_alu_en (out, 1); O_alu_op (out, 4); O_alu_s1 and O_alu_s2 (out, 32); I_alu_busy (in, 1); I_alu_data (in, 32, registered ALU result); I_alu_lt, I_alu_ltu, I_alu_eq (in, 1 each).
REQ-006 SHALL have O_busy, out, 1, high whenever the FSM is not in IDLE.

Function
REQ-007 SHALL implement the FSM states IDLE, EXEC and RESP.
REQ-008 IDLE: if any I_pN_req is high, pick a winner, pulse its O_pN_gnt for that cycle, latch op/s1/s2 of the winner and the winner index, and go to EXEC at the next edge.
REQ-009 Requester obligation: hold op and operands stable while req is high and gnt is low; req may drop or stay high after gnt; a request still high after done is treated as a new request.
REQ-010 EXEC: O_alu_en = 1; O_alu_op, O_alu_s1 and O_alu_s2 driven from the latched request and stable throughout EXEC.
REQ-011 EXEC exit: at an edge with I_alu_busy = 0, go to RESP; with I_alu_busy = 1, stay in EXEC (multi-cycle MUL*).
REQ-012 RESP: O_alu_en = 0; at the closing edge, copy I_alu_data and the lt, ltu and eq flags into the winner's result registers and go to IDLE.
REQ-013 O_pN_done SHALL pulse for exactly one cycle, the cycle after RESP; O_pN_data and the flags hold until that port's next done.
REQ-014 Latency for a single-cycle op: req sampled at edge 0 -> EXEC in cycle 1 -> RESP in cycle 2 -> done in cycle 3; a new grant is allowed in the done cycle (back-to-back issue every 3 cycles).
REQ-015 O_pN_gnt SHALL be asserted only in IDLE, for at most one port per cycle; a port never gets gnt while its own previous op is still in progress.
REQ-016 Non-winning requests SHALL be ignored until IDLE; no queueing beyond the one request being executed.
REQ-017 When the ALU is not granted, O_alu_en = 0; O_alu_op, O_alu_s1 and O_alu_s2 keep their last values (no toggling).

Reset
REQ-018 Assertion of I_reset_n = 0 SHALL immediately force IDLE and clear the RR pointer to port 0.
REQ-019 During reset, all gnt, done, O_alu_en and O_busy outputs SHALL be 0, and all data, flags, op and operand registers SHALL be 0.
REQ-020 Reset mid-EXEC or mid-RESP SHALL abort the operation with no done pulse; deassertion resumes at IDLE on the next edge.

Configuration
REQ-021 With ALUARB_RR_EN defined: round-robin arbitration; the RR pointer toggles to the non-winner after each grant; on a tie the pointer's port wins.
REQ-022 Without ALUARB_RR_EN: fixed priority, port 0 always wins a tie; no pointer register is instantiated.

Structure
REQ-023 ALUOP codes SHALL come from the shared header cpu/aludefs.vh; FSM state encodings SHALL be added there as ALUARB_* constants.
REQ-024 Winner selection SHALL be one combinational sub-module, spu32_cpu_aluarb_pick, with inputs (req0, req1, rr_ptr) and output (winner, valid).

Verification
REQ-025 Single request, port0 ADD s1=5, s2=7: gnt in cycle 0, alu_en in cycle 1 only, done0 in cycle 3, O_p0_data = 12.
REQ-026 Port1 MUL s1=3, s2=4 with I_alu_busy high for 4 EXEC cycles: alu_en and operands stable for 5 cycles, done1 2 cycles after busy falls, data = 12.
REQ-027 Both ports request continuously, SLTU, with RR_EN: grants alternate 0, 1, 0, 1 every 3 cycles; without RR_EN: port0 always wins.
REQ-028 Port0 SLT s1=0xFFFFFFFF, s2=1: done0 with lt = 1, ltu = 0, eq = 0; port1 data unchanged.
REQ-029 Reset pulse asserted in EXEC: outputs 0 asynchronously, no done; after release, port1 request granted normally.

Source files
------------

// File: rtl/spu32_cpu_aluarb_pkg.sv
// Shared definitions for the SPU32 ALU arbiter: ALUOP codes, FSM encodings, result record.
// Latency: n/a (definitions only).
// Backpressure: n/a. Optional feature macro used by the arbiter: ALUARB_RR_EN.
package spu32_cpu_aluarb_pkg;

    // ALUOP codes shared with the ALU
    localparam logic [3:0] ALUOP_ADD  = 4'd0;
    localparam logic [3:0] ALUOP_SUB  = 4'd1;
    localparam logic [3:0] ALUOP_AND  = 4'd2;
    localparam logic [3:0] ALUOP_OR   = 4'd3;
    localparam logic [3:0] ALUOP_XOR  = 4'd4;
    localparam logic [3:0] ALUOP_SLT  = 4'd5;
    localparam logic [3:0] ALUOP_SLTU = 4'd6;
    localparam logic [3:0] ALUOP_SLL  = 4'd7;
    localparam logic [3:0] ALUOP_SRL  = 4'd8;
    localparam logic [3:0] ALUOP_SRA  = 4'd9;
    localparam logic [3:0] ALUOP_MUL  = 4'd10;

    // Arbiter FSM encodings
    localparam logic [1:0] ALUARB_IDLE = 2'd0;
    localparam logic [1:0] ALUARB_EXEC = 2'd1;
    localparam logic [1:0] ALUARB_RESP = 2'd2;

    // Per-port result record captured at the end of RESP
    typedef struct packed {
        logic [31:0] data;
        logic        lt;
        logic        ltu;
        logic        eq;
    } aluarb_res_t;

endpackage

// File: rtl/spu32_cpu_aluarb_pick.sv
// Winner selection between two ALU requesters; tie goes to rr_ptr.
// Latency: purely combinational.
// Backpressure: none; ports: req0, req1, rr_ptr in; winner (0/1), valid (any request) out.
module spu32_cpu_aluarb_pick (
    input  logic req0,
    input  logic req1,
    input  logic rr_ptr,
    output logic winner,
    output logic valid
);

    always_comb begin
        valid  = req0 | req1;
        winner = (req0 & req1) ? rr_ptr : req1;
    end

endmodule

// File: rtl/spu32_cpu_aluarb.sv
// Two-port arbiter sharing one ALU: IDLE grants a winner, EXEC drives the ALU, RESP captures the result.
// Latency: grant in cycle 0, EXEC from cycle 1 (extended while I_alu_busy), RESP, done one cycle after RESP.
// Backpressure: one request in flight; losers simply wait in IDLE. ALUARB_RR_EN selects round-robin, else port 0 priority.
// Ports: per requester req/op/s1/s2 in, gnt/done/data/lt/ltu/eq out; ALU en/op/s1/s2 out, busy/data/flags in; O_busy.
module spu32_cpu_aluarb
    import spu32_cpu_aluarb_pkg::*;
(
    input  logic        I_clk,
    input  logic        I_reset_n,
    input  logic        I_p0_req,
    input  logic [3:0]  I_p0_op,
    input  logic [31:0] I_p0_s1,
    input  logic [31:0] I_p0_s2,
    output logic        O_p0_gnt,
    output logic        O_p0_done,
    output logic [31:0] O_p0_data,
    output logic        O_p0_lt,
    output logic        O_p0_ltu,
    output logic        O_p0_eq,
    input  logic        I_p1_req,
    input  logic [3:0]  I_p1_op,
    input  logic [31:0] I_p1_s1,
    input  logic [31:0] I_p1_s2,
    output logic        O_p1_gnt,
    output logic        O_p1_done,
    output logic [31:0] O_p1_data,
    output logic        O_p1_lt,
    output logic        O_p1_ltu,
    output logic        O_p1_eq,
    output logic        O_alu_en,
    output logic [3:0]  O_alu_op,
    output logic [31:0] O_alu_s1,
    output logic [31:0] O_alu_s2,
    input  logic        I_alu_busy,
    input  logic [31:0] I_alu_data,
    input  logic        I_alu_lt,
    input  logic        I_alu_ltu,
    input  logic        I_alu_eq,
    output logic        O_busy
);

    logic [1:0]  state_q, state_d;
    logic        win_q, win_d;
    logic [3:0]  op_q, op_d;
    logic [31:0] s1_q, s1_d;
    logic [31:0] s2_q, s2_d;
    aluarb_res_t res0_q, res0_d;
    aluarb_res_t res1_q, res1_d;
    logic        done0_q, done0_d;
    logic        done1_q, done1_d;
    logic        rr_ptr;
    logic        pick_winner;
    logic        pick_valid;
    logic        grant;

`ifdef ALUARB_RR_EN
    logic        rr_q, rr_d;
    assign rr_ptr = rr_q;
`else
    assign rr_ptr = 1'b0;
`endif

    spu32_cpu_aluarb_pick u_pick (
        .req0   (I_p0_req),
        .req1   (I_p1_req),
        .rr_ptr (rr_ptr),
        .winner (pick_winner),
        .valid  (pick_valid)
    );

    // Grant is combinational; gating with reset keeps it low while reset is held
    assign grant    = I_reset_n & (state_q == ALUARB_IDLE) & pick_valid;
    assign O_p0_gnt = grant & ~pick_winner;
    assign O_p1_gnt = grant & pick_winner;

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        op_d    = op_q;
        s1_d    = s1_q;
        s2_d    = s2_q;
        res0_d  = res0_q;
        res1_d  = res1_q;
        done0_d = 1'b0;
        done1_d = 1'b0;
`ifdef ALUARB_RR_EN
        rr_d    = rr_q;
`endif
        case (state_q)
            ALUARB_IDLE: begin
                if (pick_valid) begin
                    win_d   = pick_winner;
                    op_d    = pick_winner ? I_p1_op : I_p0_op;
                    s1_d    = pick_winner ? I_p1_s1 : I_p0_s1;
                    s2_d    = pick_winner ? I_p1_s2 : I_p0_s2;
                    state_d = ALUARB_EXEC;
`ifdef ALUARB_RR_EN
                    rr_d    = ~pick_winner;
`endif
                end
            end
            ALUARB_EXEC: begin
                if (!I_alu_busy) begin
                    state_d = ALUARB_RESP;
                end
            end
            ALUARB_RESP: begin
                if (win_q) begin
                    res1_d  = '{data: I_alu_data, lt: I_alu_lt, ltu: I_alu_ltu, eq: I_alu_eq};
                    done1_d = 1'b1;
                end else begin
                    res0_d  = '{data: I_alu_data, lt: I_alu_lt, ltu: I_alu_ltu, eq: I_alu_eq};
                    done0_d = 1'b1;
                end
                state_d = ALUARB_IDLE;
            end
            default: state_d = ALUARB_IDLE;
        endcase
    end

    always_ff @(posedge I_clk or negedge I_reset_n) begin
        if (!I_reset_n) begin
            state_q <= ALUARB_IDLE;
            win_q   <= 1'b0;
            op_q    <= '0;
            s1_q    <= '0;
            s2_q    <= '0;
            res0_q  <= '0;
            res1_q  <= '0;
            done0_q <= 1'b0;
            done1_q <= 1'b0;
`ifdef ALUARB_RR_EN
            rr_q    <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            win_q   <= win_d;
            op_q    <= op_d;
            s1_q    <= s1_d;
            s2_q    <= s2_d;
            res0_q  <= res0_d;
            res1_q  <= res1_d;
            done0_q <= done0_d;
            done1_q <= done1_d;
`ifdef ALUARB_RR_EN
            rr_q    <= rr_d;
`endif
        end
    end

    // ALU operands come straight from the latched request, so they hold outside EXEC
    assign O_alu_en  = (state_q == ALUARB_EXEC);
    assign O_alu_op  = op_q;
    assign O_alu_s1  = s1_q;
    assign O_alu_s2  = s2_q;
    assign O_busy    = (state_q != ALUARB_IDLE);

    assign O_p0_done = done0_q;
    assign O_p0_data = res0_q.data;
    assign O_p0_lt   = res0_q.lt;
    assign O_p0_ltu  = res0_q.ltu;
    assign O_p0_eq   = res0_q.eq;
    assign O_p1_done = done1_q;
    assign O_p1_data = res1_q.data;
    assign O_p1_lt   = res1_q.lt;
    assign O_p1_ltu  = res1_q.ltu;
    assign O_p1_eq   = res1_q.eq;

endmodule
